// File: rtl/pll_drp_rmw.sv
// pll_drp_rmw: DRP initiator for a PLLE2_ADV / MMCME2_ADV DRP port.
// Performs single-register reads and masked read-modify-write cycles.
// During a write the PLL is held in reset, then LOCKED is awaited.
// Everything runs on the DRP clock.
module pll_drp_rmw #(
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int CNT_W        = 17
) (
    input  logic        clk,
    input  logic        reset,
    // command / response towards the reconfiguration controller
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [6:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    input  logic [15:0] cmd_mask,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    // DRP port towards the PLL primitive
    output logic [6:0]  drp_daddr,
    output logic [15:0] drp_di,
    output logic        drp_den,
    output logic        drp_dwe,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        pll_rst,
    input  logic        pll_locked
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_LOCK_WAIT,
        S_RESP
    } state_t;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_DRDY = 2'd1;
    localparam logic [1:0] ERR_LOCK = 2'd2;

    // Terminal counts for the shared wait counter.
    localparam logic [CNT_W-1:0] DRDY_TC     = CNT_W'(DRDY_TIMEOUT);
    localparam logic [CNT_W-1:0] LOCK_TC     = CNT_W'(LOCK_TIMEOUT);
    // LOCKED may still show the pre-reset lock for a couple of cycles.
    localparam logic [CNT_W-1:0] LOCK_IGNORE = CNT_W'(2);

    // Masked merge: mask bit 1 keeps the current register bit.
    function automatic logic [15:0] merge_rmw(input logic [15:0] old_v,
                                              input logic [15:0] new_v,
                                              input logic [15:0] keep);
        return (old_v & keep) | (new_v & ~keep);
    endfunction

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic [15:0]       rsp_rdata_q;
    logic [1:0]        rsp_err_q;
    logic [6:0]        daddr_q;
    logic [15:0]       di_q;
    logic              den_q;
    logic              dwe_q;
    logic              pll_rst_q;

    // Command latches (data path, not reset)
    logic [6:0]        addr_q;
    logic [15:0]       wdata_q;
    logic [15:0]       mask_q;
    logic              write_q;
    logic [15:0]       rdata_q;
    logic [15:0]       wr_data_d;
    logic              accept;

    assign accept    = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;
    assign wr_data_d = merge_rmw(rdata_q, wdata_q, mask_q);

    // Capture the command on acceptance and the read value on read DRDY.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            mask_q  <= cmd_mask;
            write_q <= cmd_write;
            rdata_q <= '0;
        end else if ((state_q == S_RD_WAIT) && drp_drdy) begin
            rdata_q <= drp_do;
        end
    end

    // Control FSM with registered DRP, PLL-reset and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= ERR_OK;
            daddr_q     <= '0;
            di_q        <= '0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            pll_rst_q   <= 1'b0;
        end else begin
            // DEN/DWE and the response are single-cycle pulses.
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        pll_rst_q   <= cmd_write;
                        state_q     <= S_RD_REQ;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                S_RD_REQ: begin
                    den_q   <= 1'b1;
                    daddr_q <= addr_q;
                    cnt_q   <= '0;
                    state_q <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // DRDY wins over a simultaneous terminal count.
                    if (drp_drdy) begin
                        if (write_q) begin
                            state_q <= S_WR_REQ;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= drp_do;
                            rsp_err_q   <= ERR_OK;
                            state_q     <= S_RESP;
                        end
                    end else if (cnt_q >= DRDY_TC) begin
                        // Never leave the PLL parked in reset after an abort.
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata_q;
                        rsp_err_q   <= ERR_DRDY;
                        pll_rst_q   <= 1'b0;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WR_REQ: begin
                    den_q   <= 1'b1;
                    dwe_q   <= 1'b1;
                    di_q    <= wr_data_d;
                    cnt_q   <= '0;
                    state_q <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (drp_drdy) begin
                        pll_rst_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= S_LOCK_WAIT;
                    end else if (cnt_q >= DRDY_TC) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata_q;
                        rsp_err_q   <= ERR_DRDY;
                        pll_rst_q   <= 1'b0;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_LOCK_WAIT: begin
                    if ((cnt_q >= LOCK_IGNORE) && pll_locked) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata_q;
                        rsp_err_q   <= ERR_OK;
                        state_q     <= S_RESP;
                    end else if (cnt_q >= LOCK_TC) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata_q;
                        rsp_err_q   <= ERR_LOCK;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign drp_daddr = daddr_q;
    assign drp_di    = di_q;
    assign drp_den   = den_q;
    assign drp_dwe   = dwe_q;
    assign pll_rst   = pll_rst_q;

endmodule

// File: tb/tb_pll_drp_rmw.sv
// tb_pll_drp_rmw: directed bench for pll_drp_rmw with a DRP slave model
// (programmable DRDY delay) and a simple PLL lock model.
module tb_pll_drp_rmw;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [6:0]  cmd_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic [15:0] cmd_mask = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_do;
    logic        drp_drdy = 1'b0;
    logic        pll_rst;
    logic        pll_locked = 1'b0;

    always #5 clk = ~clk;

    pll_drp_rmw #(
        .DRDY_TIMEOUT(64),
        .LOCK_TIMEOUT(100),
        .CNT_W(17)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_den(drp_den), .drp_dwe(drp_dwe),
        .drp_do(drp_do), .drp_drdy(drp_drdy),
        .pll_rst(pll_rst), .pll_locked(pll_locked)
    );

    // DRP slave: DRDY pulses model_delay cycles after the DEN cycle
    int          model_delay = 3;
    bit          model_mute = 1'b0;
    logic [15:0] model_do = '0;
    int          pend = 0;
    assign drp_do = model_do;

    always @(posedge clk) begin
        if (drp_den && !model_mute) begin
            pend     <= model_delay - 1;
            drp_drdy <= (model_delay == 1);
        end else if (pend != 0) begin
            pend     <= pend - 1;
            drp_drdy <= (pend == 1);
        end else begin
            drp_drdy <= 1'b0;
        end
    end

    // PLL lock: drops in reset, relocks 4 cycles after release
    bit lock_ok = 1'b1;
    bit lock_force = 1'b0;
    int lock_cnt = 0;
    always @(posedge clk) begin
        if (pll_rst && !lock_force) begin
            lock_cnt   <= 0;
            pll_locked <= 1'b0;
        end else begin
            if (lock_cnt < 1000) lock_cnt <= lock_cnt + 1;
            pll_locked <= lock_force || (lock_ok && lock_cnt >= 3);
        end
    end

    // DRP bus monitor
    int          den_cnt = 0, wr_den_cnt = 0, rst_seen = 0, overlap = 0;
    logic [15:0] last_di = '0;
    logic [6:0]  last_daddr = '0;
    logic        last_dwe = 1'b0, rst_at_wr_drdy = 1'b0, den_prev = 1'b0, outstanding = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            outstanding = 1'b0;
            den_prev    = 1'b0;
        end else begin
            if (drp_den) begin
                if (den_prev || outstanding) overlap++;
                den_cnt++;
                outstanding = 1'b1;
                last_daddr  = drp_daddr;
                last_dwe    = drp_dwe;
                if (drp_dwe) begin
                    wr_den_cnt++;
                    last_di = drp_di;
                end
            end
            if (drp_drdy) begin
                outstanding = 1'b0;
                if (last_dwe) rst_at_wr_drdy = pll_rst;
            end
            if (rsp_valid) outstanding = 1'b0;
            if (pll_rst) rst_seen++;
            den_prev = drp_den;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_stats();
        den_cnt = 0; wr_den_cnt = 0; rst_seen = 0; overlap = 0;
        last_di = '0; last_daddr = '0; last_dwe = 1'b0; rst_at_wr_drdy = 1'b0;
    endtask

    // Present one command in an IDLE cycle; returns just after the accept edge.
    task automatic issue(input logic wr, input logic [6:0] a,
                         input logic [15:0] wd, input logic [15:0] m);
        int k;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("issue_ready", 32'(cmd_ready), 32'd1);
        clear_stats();
        cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_mask = m;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // n = cycles from the accept cycle to rsp_valid; -1 if it never came.
    task automatic wait_rsp(input int maxc, output int n);
        n = 1;
        @(negedge clk);
        while (!rsp_valid && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) n = -1;
    endtask

    int lat, r1, r2, rdy, nrsp;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_ctl", 32'({rsp_valid, rsp_err, drp_den, drp_dwe, pll_rst}), 32'd0);
        chk("rst_data", {rsp_rdata, drp_di}, 32'd0);
        chk("rst_daddr", 32'(drp_daddr), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        // plain read, DRDY 3 cycles after DEN
        model_do = 16'h1234; model_delay = 3;
        issue(1'b0, 7'h08, 16'h0000, 16'h0000);
        wait_rsp(200, lat);
        chk("rd_lat", 32'(lat), 32'd6);
        chk("rd_rdata", 32'(rsp_rdata), 32'h1234);
        chk("rd_err", 32'(rsp_err), 32'd0);
        chk("rd_den_cnt", 32'(den_cnt), 32'd1);
        chk("rd_wr_den", 32'(wr_den_cnt), 32'd0);
        chk("rd_daddr", 32'(last_daddr), 32'h08);
        chk("rd_no_pllrst", 32'(rst_seen), 32'd0);

        // read with minimum DRDY delay, top address
        model_do = 16'hFFFF; model_delay = 1;
        issue(1'b0, 7'h7F, 16'h0000, 16'h0000);
        wait_rsp(200, lat);
        chk("rd1_lat", 32'(lat), 32'd4);
        chk("rd1_rdata", 32'(rsp_rdata), 32'hFFFF);
        chk("rd1_daddr", 32'(last_daddr), 32'h7F);

        // masked RMW
        model_do = 16'hABCD; model_delay = 3;
        issue(1'b1, 7'h09, 16'h0041, 16'hFF00);
        wait_rsp(300, lat);
        chk("rmw_lat", 32'(lat), 32'd16);
        chk("rmw_rdata", 32'(rsp_rdata), 32'hABCD);
        chk("rmw_err", 32'(rsp_err), 32'd0);
        chk("rmw_den_cnt", 32'(den_cnt), 32'd2);
        chk("rmw_wr_den", 32'(wr_den_cnt), 32'd1);
        chk("rmw_di", 32'(last_di), 32'hAB41);
        chk("rmw_rst_cycles", 32'(rst_seen), 32'd10);
        chk("rmw_rst_at_drdy", 32'(rst_at_wr_drdy), 32'd1);
        chk("rmw_rst_after", 32'(pll_rst), 32'd0);

        // stale LOCKED stays high: first two LOCK_WAIT cycles are ignored
        lock_force = 1'b1;
        model_do = 16'h00FF;
        issue(1'b1, 7'h0A, 16'h1234, 16'h0F0F);
        wait_rsp(300, lat);
        lock_force = 1'b0;
        chk("stale_lat", 32'(lat), 32'd14);
        chk("stale_di", 32'(last_di), 32'h103F);
        chk("stale_rdata", 32'(rsp_rdata), 32'h00FF);

        // DRDY on the terminal count is still a success
        model_do = 16'h0001; model_delay = 64;
        issue(1'b0, 7'h0B, 16'h0000, 16'h0000);
        wait_rsp(300, lat);
        chk("tc_lat", 32'(lat), 32'd67);
        chk("tc_err", 32'(rsp_err), 32'd0);
        chk("tc_rdata", 32'(rsp_rdata), 32'h0001);
        model_delay = 3;

        // DRDY never comes (write command, PLL reset must be released)
        model_mute = 1'b1;
        issue(1'b1, 7'h0C, 16'h5555, 16'h0000);
        wait_rsp(300, lat);
        chk("to_lat", 32'(lat), 32'd67);
        chk("to_err", 32'(rsp_err), 32'd1);
        chk("to_den_cnt", 32'(den_cnt), 32'd1);
        @(negedge clk);
        chk("to_pllrst", 32'(pll_rst), 32'd0);
        model_mute = 1'b0;

        // lock never comes
        lock_ok = 1'b0;
        model_do = 16'hC3C3;
        issue(1'b1, 7'h0D, 16'h0000, 16'hFFFF);
        wait_rsp(400, lat);
        chk("lk_lat", 32'(lat), 32'd112);
        chk("lk_err", 32'(rsp_err), 32'd2);
        chk("lk_rdata", 32'(rsp_rdata), 32'hC3C3);
        chk("lk_pllrst", 32'(pll_rst), 32'd0);
        lock_ok = 1'b1;

        // back-to-back reads with cmd_valid held high
        model_do = 16'h0BB0;
        clear_stats();
        @(negedge clk);
        cmd_write = 1'b0; cmd_addr = 7'h11; cmd_valid = 1'b1;
        r1 = 0; r2 = 0; rdy = 0;
        for (int i = 1; i <= 40 && r2 == 0; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                if (r1 == 0) r1 = i;
                else r2 = i;
            end
            if (cmd_ready) rdy++;
        end
        cmd_valid = 1'b0;
        chk("b2b_rsp1", 32'(r1), 32'd6);
        chk("b2b_rsp2", 32'(r2), 32'd13);
        chk("b2b_ready_cycles", 32'(rdy), 32'd1);
        chk("b2b_den_cnt", 32'(den_cnt), 32'd2);
        chk("b2b_overlap", 32'(overlap), 32'd0);

        // reset while waiting for read DRDY of a write command
        model_mute = 1'b1;
        issue(1'b1, 7'h12, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        chk("rdw_pre_pllrst", 32'(pll_rst), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rdw_ctl", 32'({cmd_ready, rsp_valid, rsp_err, drp_den, drp_dwe, pll_rst}), 32'd0);
        chk("rdw_data", {rsp_rdata, drp_di}, 32'd0);
        chk("rdw_daddr", 32'(drp_daddr), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rdw_ready", 32'(cmd_ready), 32'd1);
        nrsp = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
        end
        chk("rdw_no_rsp", 32'(nrsp), 32'd0);
        model_mute = 1'b0;

        // reset while waiting for lock
        lock_ok = 1'b0;
        model_do = 16'h7777;
        issue(1'b1, 7'h13, 16'h0000, 16'h00FF);
        repeat (12) @(negedge clk);
        chk("lkw_pre_rsp", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("lkw_ctl", 32'({cmd_ready, rsp_valid, rsp_err, drp_den, drp_dwe, pll_rst}), 32'd0);
        chk("lkw_data", {rsp_rdata, drp_di}, 32'd0);
        reset = 1'b0;
        nrsp = 0;
        repeat (130) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
        end
        chk("lkw_no_rsp", 32'(nrsp), 32'd0);
        lock_ok = 1'b1;

        // normal read after the aborts
        model_do = 16'h5A5A;
        issue(1'b0, 7'h20, 16'h0000, 16'h0000);
        wait_rsp(200, lat);
        chk("post_lat", 32'(lat), 32'd6);
        chk("post_rdata", 32'(rsp_rdata), 32'h5A5A);
        chk("post_err", 32'(rsp_err), 32'd0);
        chk("post_daddr", 32'(last_daddr), 32'h20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
